// File: rtl/adaptive_filter_pkg.sv
// Shared types and saturating arithmetic for the adaptive first-order filter.
// Samples are two's complement; the binary point never moves through the datapath.
package adaptive_filter_pkg;

  localparam int WORDLENGTH        = 14;
  localparam int FRACTIONAL_LENGTH = 6;

  typedef enum logic {
    MODE_DIFF = 1'b0,
    MODE_INT  = 1'b1
  } mode_t;

  // a +/- b on sign-extended operands, clamped to the WORDLENGTH-bit signed range.
  function automatic logic [WORDLENGTH-1:0] sat_add(
    input logic [WORDLENGTH-1:0] a,
    input logic [WORDLENGTH-1:0] b,
    input logic                  sub
  );
    logic signed [WORDLENGTH:0] ea;
    logic signed [WORDLENGTH:0] eb;
    logic signed [WORDLENGTH:0] s;
    ea = {a[WORDLENGTH-1], a};
    eb = {b[WORDLENGTH-1], b};
    s  = sub ? (ea - eb) : (ea + eb);
    if (s[WORDLENGTH] != s[WORDLENGTH-1])
      sat_add = s[WORDLENGTH] ? {1'b1, {(WORDLENGTH-1){1'b0}}}
                              : {1'b0, {(WORDLENGTH-1){1'b1}}};
    else
      sat_add = s[WORDLENGTH-1:0];
  endfunction

endpackage

// File: rtl/adaptive_filter_sat_addsub.sv
// Combinational saturating add/subtract shared by the integrate and differentiate paths.
module adaptive_filter_sat_addsub
  import adaptive_filter_pkg::*;
#(
  parameter int W = WORDLENGTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] res_o
);

  if (W == WORDLENGTH) begin : g_pkg_width
    assign res_o = sat_add(a_i, b_i, sub_i);
  end else begin : g_generic_width
    logic signed [W:0] ea;
    logic signed [W:0] eb;
    logic signed [W:0] s;
    always_comb begin
      ea    = {a_i[W-1], a_i};
      eb    = {b_i[W-1], b_i};
      s     = sub_i ? (ea - eb) : (ea + eb);
      res_o = s[W-1:0];
      // Overflow shows up as disagreement between the guard bit and the sign bit.
      if (s[W] != s[W-1])
        res_o = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/adaptive_filter.sv
// Streaming first-order filter: running-sum integrator (ctrl=1) or first-difference
// differentiator (ctrl=0), one registered output per accepted sample, no backpressure.
module adaptive_filter
  import adaptive_filter_pkg::*;
#(
  parameter int WORDLENGTH        = adaptive_filter_pkg::WORDLENGTH,
  parameter int FRACTIONAL_LENGTH = adaptive_filter_pkg::FRACTIONAL_LENGTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  ctrl,
  input  logic [WORDLENGTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic [WORDLENGTH-1:0] m_tdata,
  output logic                  m_tvalid
);

  // Stream handshake: a sample is taken on every rising edge where s_tvalid=1 (there is
  // no tready); m_tvalid follows s_tvalid one cycle later and m_tdata holds between samples.

  if (FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_bad_format
    $error("adaptive_filter: FRACTIONAL_LENGTH must lie in [0, WORDLENGTH-1]");
  end

  mode_t                 mode_in;
  mode_t                 prev_mode_q, prev_mode_d;
  logic [WORDLENGTH-1:0] prev_x_q, prev_x_d;
  logic [WORDLENGTH-1:0] acc_q, acc_d;
  logic [WORDLENGTH-1:0] y_q, y_d;
  logic                  valid_q, valid_d;

  logic [WORDLENGTH-1:0] op_a;
  logic [WORDLENGTH-1:0] op_b;
  logic                  op_sub;
  logic [WORDLENGTH-1:0] op_res;

  assign mode_in = mode_t'(ctrl);

  // Integrate: acc + x, with acc forced to zero on entry from differentiate so the sum
  // restarts at x. Differentiate: x - prev_x.
  always_comb begin
    op_sub = 1'b0;
    op_a   = '0;
    op_b   = s_tdata;
    if (mode_in == MODE_DIFF) begin
      op_sub = 1'b1;
      op_a   = s_tdata;
      op_b   = prev_x_q;
    end else if (prev_mode_q == MODE_INT) begin
      op_a   = acc_q;
    end
  end

  adaptive_filter_sat_addsub #(
    .W (WORDLENGTH)
  ) u_sat_addsub (
    .a_i   (op_a),
    .b_i   (op_b),
    .sub_i (op_sub),
    .res_o (op_res)
  );

  always_comb begin
    prev_mode_d = prev_mode_q;
    prev_x_d    = prev_x_q;
    acc_d       = acc_q;
    y_d         = y_q;
    valid_d     = s_tvalid;
    if (s_tvalid) begin
      prev_mode_d = mode_in;
      prev_x_d    = s_tdata;
      acc_d       = op_res;
      y_d         = op_res;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_mode_q <= MODE_DIFF;
      prev_x_q    <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
    end else begin
      prev_mode_q <= prev_mode_d;
      prev_x_q    <= prev_x_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      valid_q     <= valid_d;
    end
  end

  assign m_tdata  = y_q;
  assign m_tvalid = valid_q;

endmodule

// File: tb/tb_adaptive_filter.sv
// Self-checking bench for adaptive_filter: directed vectors with hand-computed results,
// then randomized traffic compared cycle by cycle against an integer reference model.
module tb_adaptive_filter;

  localparam int W    = 14;
  localparam int MAXV = 8191;
  localparam int MINV = -8192;

  logic         clk = 1'b0;
  logic         srst;
  logic         ctrl;
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, plain integers.
  int  mdl_px;
  int  mdl_acc;
  bit  mdl_int;
  int  mdl_y;
  bit  mdl_v;

  // Expected directed results, consumed in order.
  logic [W-1:0] exp_q[$];

  adaptive_filter dut (
    .clk      (clk),
    .srst     (srst),
    .ctrl     (ctrl),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic void model_step(input bit rst, input bit v, input bit c, input int x);
    if (rst) begin
      mdl_px = 0; mdl_acc = 0; mdl_int = 0; mdl_y = 0; mdl_v = 0;
    end else if (v) begin
      if (!c)           mdl_y = clamp(x - mdl_px);
      else if (mdl_int) mdl_y = clamp(mdl_acc + x);
      else              mdl_y = x;
      mdl_px  = x;
      mdl_acc = mdl_y;
      mdl_int = c;
      mdl_v   = 1;
    end else begin
      mdl_v = 0;
    end
  endfunction

  // Drive one cycle on the falling edge, then compare just after the rising edge.
  task automatic step(input bit rst, input bit v, input bit c, input int x, input string tag);
    @(negedge clk);
    srst     = rst;
    s_tvalid = v;
    ctrl     = c;
    s_tdata  = W'(x);
    model_step(rst, v, c, x);
    @(posedge clk);
    #1;
    check_val({tag, ".valid"}, int'(m_tvalid), int'(mdl_v));
    check_val({tag, ".data"}, int'($signed(m_tdata)), mdl_y);
  endtask

  // Directed sample whose expected output comes from the hand-worked table.
  task automatic dir(input bit c, input int x, input int y, input string tag);
    exp_q.push_back(W'(y));
    step(1'b0, 1'b1, c, x, tag);
    check_val({tag, ".table"}, int'($signed(m_tdata)), int'($signed(exp_q.pop_front())));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 1'b1, 1234, "reset");
  endtask

  initial begin
    srst = 1'b1; s_tvalid = 1'b0; ctrl = 1'b0; s_tdata = '0;
    model_step(1'b1, 1'b0, 1'b0, 0);

    // Reset held with s_tvalid high: output stays invalid and zero.
    do_reset(3);
    dir(1'b1, 77, 77, "post_reset_int");

    do_reset(1);
    dir(1'b0, 64, 64, "diff0");
    dir(1'b0, 128, 64, "diff1");
    dir(1'b0, 128, 0, "diff2");
    dir(1'b0, 0, -128, "diff3");

    do_reset(1);
    dir(1'b1, 64, 64, "int0");
    dir(1'b1, 64, 128, "int1");
    dir(1'b1, 64, 192, "int2");
    dir(1'b1, -256, -64, "int3");

    do_reset(1);
    dir(1'b1, 8000, 8000, "sat_int0");
    dir(1'b1, 8000, 8191, "sat_int1");
    dir(1'b1, -8192, -1, "sat_int2");
    dir(1'b1, -8192, -8192, "sat_int3");
    do_reset(1);
    dir(1'b0, 8191, 8191, "sat_diff0");
    dir(1'b0, -8192, -8192, "sat_diff1");

    do_reset(1);
    dir(1'b1, 64, 64, "sw0");
    dir(1'b1, 64, 128, "sw1");
    dir(1'b0, 192, 128, "sw2");
    dir(1'b1, 10, 10, "sw3_restart");
    dir(1'b1, 5, 15, "sw4");

    do_reset(1);
    dir(1'b0, 64, 64, "gap0");
    step(1'b0, 1'b0, 1'b1, 999, "gap_idle0");
    check_val("gap_hold0", int'($signed(m_tdata)), 64);
    step(1'b0, 1'b0, 1'b0, 999, "gap_idle1");
    check_val("gap_hold1", int'($signed(m_tdata)), 64);
    dir(1'b0, 96, 32, "gap1");

    // Mid-stream reset wipes history.
    dir(1'b0, 50, -46, "mid0");
    do_reset(1);
    dir(1'b0, 30, 30, "mid_after_reset");

    // Randomized traffic with occasional resets and full-scale samples.
    for (int i = 0; i < 1500; i++) begin
      bit rst, v, c;
      int x;
      rst = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 99) < 75);
      c   = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       x = MAXV;
        1:       x = MINV;
        2:       x = $urandom_range(0, 200) - 100;
        default: x = int'($urandom_range(0, 16383)) - 8192;
      endcase
      step(rst, v, c, x, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
